// File: rtl/data_structures.sv
// Shared types and sizing for the out-of-order core: RS/ROB geometry, operand and entry records,
// and the CDB snoop rule every operand holder applies.
package data_structures;

  localparam int RS_SIZE      = 8;
  localparam int ROB_SIZE     = 32;
  localparam int ROB_IDX_SIZE = $clog2(ROB_SIZE);
  localparam int GPR_SIZE     = 64;
  localparam int OCC_W        = $clog2(RS_SIZE + 1);

  typedef logic [ROB_IDX_SIZE-1:0] rob_idx_t;
  typedef logic [GPR_SIZE-1:0]     gpr_t;

  // Operand: when !valid, rob_index names the producer still in flight.
  typedef struct packed {
    logic     valid;
    rob_idx_t rob_index;
    gpr_t     value;
  } rs_op;

  typedef struct packed {
    rs_op     op1;
    rs_op     op2;
    rob_idx_t dst_rob;
  } rs_entry;

  typedef struct packed {
    gpr_t     val_a;
    gpr_t     val_b;
    rob_idx_t dst_rob;
  } issue_pkt_t;

  // A waiting operand whose producer tag is on the CDB becomes valid; valid operands never change.
  function automatic rs_op cdb_snoop(input rs_op op, input logic cdb_valid,
                                     input rob_idx_t cdb_tag, input gpr_t cdb_value);
    cdb_snoop = op;
    if (cdb_valid && !op.valid && (op.rob_index == cdb_tag)) begin
      cdb_snoop.valid = 1'b1;
      cdb_snoop.value = cdb_value;
    end
  endfunction

endpackage

// File: rtl/rs_oldest_picker.sv
// Age-matrix oldest-ready picker. older[i][j]=1 means entry j is older than entry i;
// the diagonal is always zero. Returns a one-hot grant of the oldest ready entry.
module rs_oldest_picker
  import data_structures::*;
#(
  parameter int N = RS_SIZE
) (
  input  logic [N-1:0]        ready,
  input  logic [N-1:0][N-1:0] older,
  output logic [N-1:0]        grant,
  output logic                any_ready
);

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = ready[i] & ~|(ready & older[i]);
    end
  end

  assign any_ready = |ready;

endmodule

// File: rtl/rs_issue_sched.sv
// Single-bank reservation station: allocates from dispatch, wakes operands from the CDB and
// moves the oldest ready entry into a registered issue slot drained by a valid/ready handshake.
module rs_issue_sched
  import data_structures::*;
(
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  input  rs_op                    alloc_op1,
  input  rs_op                    alloc_op2,
  input  logic [ROB_IDX_SIZE-1:0] alloc_dst_rob,
  input  logic                    cdb_valid,
  input  logic [ROB_IDX_SIZE-1:0] cdb_rob_index,
  input  logic [GPR_SIZE-1:0]     cdb_value,
  output logic                    issue_valid,
  input  logic                    issue_ready,
  output logic [GPR_SIZE-1:0]     issue_val_a,
  output logic [GPR_SIZE-1:0]     issue_val_b,
  output logic [ROB_IDX_SIZE-1:0] issue_dst_rob,
  output logic [OCC_W-1:0]        occupancy
);

  logic [RS_SIZE-1:0]              entry_valid;
  rs_entry                         entries [RS_SIZE];
  logic [RS_SIZE-1:0][RS_SIZE-1:0] older;
  issue_pkt_t                      issue_pkt;

  logic [RS_SIZE-1:0] ready, grant, free_vec, alloc_sel;
  logic               any_ready, alloc_fire, load_fire;
  issue_pkt_t         picked;

  // Free-slot choice uses registered validity, so an entry issued this edge is reused next cycle.
  assign free_vec    = ~entry_valid;
  assign alloc_sel   = free_vec & (~free_vec + RS_SIZE'(1));
  assign alloc_ready = |free_vec;
  assign alloc_fire  = alloc_valid & alloc_ready & ~flush;

  always_comb begin
    ready = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = entry_valid[i] & entries[i].op1.valid & entries[i].op2.valid;
    end
  end

  rs_oldest_picker #(.N(RS_SIZE)) u_picker (
    .ready     (ready),
    .older     (older),
    .grant     (grant),
    .any_ready (any_ready)
  );

  always_comb begin
    picked = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (grant[i]) begin
        picked = '{val_a: entries[i].op1.value, val_b: entries[i].op2.value,
                   dst_rob: entries[i].dst_rob};
      end
    end
  end

  assign load_fire = any_ready & (~issue_valid | issue_ready) & ~flush;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      entry_valid <= '0;
    end else if (flush) begin
      entry_valid <= '0;
    end else begin
      entry_valid <= (entry_valid & ~(load_fire ? grant : '0)) | (alloc_fire ? alloc_sel : '0);
    end
  end

  // NOTE: payload storage is deliberately not reset; entry_valid alone decides whether it is used.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      if (alloc_fire && alloc_sel[i]) begin
        entries[i].op1     <= cdb_snoop(alloc_op1, cdb_valid, cdb_rob_index, cdb_value);
        entries[i].op2     <= cdb_snoop(alloc_op2, cdb_valid, cdb_rob_index, cdb_value);
        entries[i].dst_rob <= alloc_dst_rob;
      end else begin
        entries[i].op1 <= cdb_snoop(entries[i].op1, cdb_valid, cdb_rob_index, cdb_value);
        entries[i].op2 <= cdb_snoop(entries[i].op2, cdb_valid, cdb_rob_index, cdb_value);
      end
    end
  end

  // New entry: every other entry becomes older than it (row set), it is older than none (column cleared).
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      older <= '0;
    end else if (alloc_fire) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        for (int j = 0; j < RS_SIZE; j++) begin
          if (alloc_sel[i])      older[i][j] <= (i != j);
          else if (alloc_sel[j]) older[i][j] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      issue_valid <= 1'b0;
      issue_pkt   <= '0;
    end else if (flush) begin
      issue_valid <= 1'b0;
    end else if (load_fire) begin
      issue_valid <= 1'b1;
      issue_pkt   <= picked;
    end else if (issue_ready) begin
      issue_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)        occupancy <= '0;
    else if (flush) occupancy <= '0;
    else            occupancy <= occupancy + OCC_W'(alloc_fire) - OCC_W'(load_fire);
  end

  assign issue_val_a   = issue_pkt.val_a;
  assign issue_val_b   = issue_pkt.val_b;
  assign issue_dst_rob = issue_pkt.dst_rob;

endmodule
